priority_encoder_rr: RTL and testbench

Parametrised, registered priority encoder with a selectable round-robin mode and a valid/ready output handshake. It generalises the 4-input fixed-priority encoder to N inputs. It can rotate priority so that persistent high-index requests cannot starve low-index ones. It sits between a request vector (interrupt lines, arbiter requests) and a downstream consumer that may stall.

---
 rtl/priority_encoder_rr.sv | 93 +++++++++
 tb/tb_priority_encoder_rr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered N-input priority encoder with optional
// round-robin rotation and a valid/ready result stage.
module priority_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         en,
  input  logic         mode,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_y;
  logic [W-1:0] r_ptr;
  logic         r_valid;
  logic         r_ov;
  logic         r_mode;

  logic         w_hs;
  logic         w_take;
  logic         w_upd;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_ptr;
  logic [W-1:0] w_fix;
  logic [W-1:0] w_rr;
  logic [W-1:0] w_enc;
  logic         w_found;

  assign w_hs   = r_ov && out_ready;
  assign w_take = en && (!r_ov || out_ready);

  // Only a delivered round-robin grant that found a request rotates.
  assign w_upd     = w_hs && r_valid && r_mode;
  assign w_ptr_nxt = (r_y == '0) ? LAST : r_y - 1'b1;
  assign w_ptr     = w_upd ? w_ptr_nxt : r_ptr;

  always_comb begin
    w_fix = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) w_fix = W'(i);
    end
  end

  // Walk downward from the pointer, wrapping below 0 to N-1.
  always_comb begin
    logic [W:0] t;
    t       = '0;
    w_rr    = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      t = {1'b0, w_ptr} + (W+1)'(N) - (W+1)'(k);
      if (t >= (W+1)'(N)) t = t - (W+1)'(N);
      if (!w_found && a[t[W-1:0]]) begin
        w_found = 1'b1;
        w_rr    = t[W-1:0];
      end
    end
  end

  assign w_enc = mode ? w_rr : w_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ov    <= 1'b0;
      r_ptr   <= LAST;
      r_mode  <= 1'b0;
    end else begin
      if (w_upd) r_ptr <= w_ptr_nxt;
      if (w_take) begin
        r_y     <= w_enc;
        r_valid <= |a;
        r_ov    <= 1'b1;
        r_mode  <= mode;
      end else if (w_hs) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign y         = r_y;
  assign valid     = r_valid;
  assign out_valid = r_ov;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed scenarios plus random traffic
// compared against a set-list reference model.
module tb_priority_encoder_rr;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic       en;
  logic       mode;
  logic       out_ready;
  logic [2:0] y;
  logic       valid;
  logic       out_valid;

  logic [3:0] a4;
  logic       en4;
  logic       rdy4;
  logic [1:0] y4;
  logic       v4;
  logic       ov4;

  int vecs = 0;
  int errs = 0;

  int m_ptr   = N - 1;
  int m_y     = 0;
  bit m_valid = 1'b0;
  bit m_ov    = 1'b0;
  bit m_mode  = 1'b0;

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .mode(mode),
    .y(y), .valid(valid), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  priority_encoder_rr #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .en(en4), .mode(1'b0),
    .y(y4), .valid(v4), .out_valid(ov4), .out_ready(rdy4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_enc(logic [7:0] v, bit md, int p);
    int q[$];
    int best;
    int top;
    best = -1;
    top  = 0;
    for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
    if (q.size() == 0) return 0;
    foreach (q[k]) begin
      top = q[k];
      if (q[k] <= p) best = q[k];
    end
    if (!md || best < 0) return top;
    return best;
  endfunction

  task automatic step();
    bit hs;
    bit take;
    @(posedge clk);
    hs   = m_ov && out_ready;
    take = en && (!m_ov || out_ready);
    if (!rst_n) begin
      m_y = 0; m_valid = 0; m_ov = 0; m_ptr = N - 1;
    end else begin
      if (hs && m_valid && m_mode)
        m_ptr = (m_y == 0) ? N - 1 : m_y - 1;
      if (take) begin
        m_y     = ref_enc(a, mode, m_ptr);
        m_valid = (a != 0);
        m_ov    = 1'b1;
        m_mode  = mode;
      end else if (hs) begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk("y", y, m_y);
    chk("valid", valid, m_valid);
    chk("out_valid", out_valid, m_ov);
  endtask

  int tbl[16] = '{0,0,1,1,2,2,2,2,3,3,3,3,3,3,3,3};
  int rot[5]  = '{7,2,0,7,2};

  initial begin
    rst_n = 0; en = 0; mode = 0; out_ready = 1; a = '0;
    en4 = 0; rdy4 = 1; a4 = '0;
    step(); step();
    chk("rst_y", y, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ov4", ov4, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i); en4 = 1;
      step();
      chk("fix4_y", y4, tbl[i]);
      chk("fix4_v", v4, i != 0);
      chk("fix4_ov", ov4, 1);
    end
    en4 = 0;

    mode = 1; a = 8'b1000_0101; en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_y", y, rot[i]);
      chk("rr_v", valid, 1);
    end

    mode = 0; a = 8'h10;
    step();
    chk("stall_y0", y, 4);
    out_ready = 0; a = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_y", y, 4);
      chk("stall_ov", out_valid, 1);
    end
    out_ready = 1;
    step();
    chk("unstall_y", y, 7);

    rst_n = 0; step(); rst_n = 1;
    mode = 1; a = 8'h00;
    step();
    chk("empty_v", valid, 0);
    chk("empty_ov", out_valid, 1);
    a = 8'hFF;
    step();
    chk("empty_next", y, 7);

    a = 8'b1000_0101;
    step();
    chk("pre_rst_y", y, 2);
    rst_n = 0;
    step();
    chk("mid_rst_v", valid, 0);
    chk("mid_rst_ov", out_valid, 0);
    rst_n = 1; a = 8'hFF;
    step();
    chk("post_rst_y", y, 7);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("walk_y", y, 6 - i);
    end
    mode = 0; a = 8'h0F;
    step(); chk("sw0_y", y, 3);
    step(); chk("sw0_y", y, 3);
    mode = 1; a = 8'hFF;
    step(); chk("sw1_y", y, 3);

    for (int i = 0; i < 2000; i++) begin
      a         = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'(1 << $urandom_range(0, 7));
      en        = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
